// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: state/owner types and the error read-data constant for mem_arbiter.
package mem_arb_pkg;
`include "common.svh"
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} arb_state_t;
    typedef enum logic {OWN_CPU, OWN_LD} arb_owner_t;
    localparam u32 ARB_ERR_DATA = 32'hDEADBEEF;
endpackage

// File: rtl/common.svh
// Scalar and word typedefs shared across the memory subsystem.
`ifndef COMMON_SVH
`define COMMON_SVH
typedef logic        u1;
typedef logic [31:0] u32;
`endif

// File: rtl/mem_arb_timer.sv
// mem_arb_timer: loadable down-counter with an expiry pulse, used as the ACCESS watchdog.
// Only present when MEM_ARB_TIMEOUT_EN is defined.
`ifdef MEM_ARB_TIMEOUT_EN
module mem_arb_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         expired
);
    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign expired = en && (cnt == '0);
endmodule
`endif

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin sharing of the unified memory port between the CPU and the loader.
// Define MEM_ARB_TIMEOUT_EN to bound ACCESS by TIMEOUT cycles (completes with err and ARB_ERR_DATA).
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_ready,
    input  logic          ld_req,
    input  logic          ld_we,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_wdata,
    output logic [DW-1:0] ld_rdata,
    output logic          ld_ready,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic          owner,
    output logic          err
);
    arb_state_t state;
    arb_owner_t grant;
    arb_owner_t last;
    u1          cpu_elig;
    u1          ld_elig;
    u1          pick_ld;
    u1          acc_err;

    assign cpu_elig = cpu_req && !cpu_ready;
    assign ld_elig  = ld_req && !ld_ready;
    // The pointer only matters on a tie: the loader wins it when the CPU was served last.
    assign pick_ld  = ld_elig && (!cpu_elig || last == OWN_CPU);
    assign owner    = grant;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT) + 1;
    u1 expired;

    mem_arb_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (state != ACCESS),
        .load_val (TW'(TIMEOUT - 1)),
        .en       (state == ACCESS),
        .expired  (expired)
    );

    assign acc_err = expired && !mem_ack;
`else
    assign acc_err = 1'b0;
    assign err     = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            grant     <= OWN_LD;
            last      <= OWN_LD;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_rdata <= '0;
            ld_rdata  <= '0;
            cpu_ready <= 1'b0;
            ld_ready  <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
            err       <= 1'b0;
`endif
        end else begin
            cpu_ready <= 1'b0;
            ld_ready  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (cpu_elig || ld_elig) begin
                        grant     <= pick_ld ? OWN_LD : OWN_CPU;
                        mem_en    <= 1'b1;
                        mem_we    <= pick_ld ? ld_we    : cpu_we;
                        mem_addr  <= pick_ld ? ld_addr  : cpu_addr;
                        mem_wdata <= pick_ld ? ld_wdata : cpu_wdata;
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (mem_ack || acc_err) begin
                        mem_en <= 1'b0;
                        if (grant == OWN_LD) begin
                            ld_rdata <= mem_ack ? mem_rdata : DW'(ARB_ERR_DATA);
                            ld_ready <= 1'b1;
                        end else begin
                            cpu_rdata <= mem_ack ? mem_rdata : DW'(ARB_ERR_DATA);
                            cpu_ready <= 1'b1;
                        end
`ifdef MEM_ARB_TIMEOUT_EN
                        err <= acc_err;
`endif
                        state <= DONE;
                    end
                end
                DONE: begin
                    last  <= grant;
`ifdef MEM_ARB_TIMEOUT_EN
                    err   <= 1'b0;
`endif
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized bench for mem_arbiter against a transaction-level arbitration and memory model.
// Timeout checks are compiled in when MEM_ARB_TIMEOUT_EN is defined.
module tb_mem_arbiter;
    localparam int TO = 8;

    logic        clk;
    logic        rst_n;
    logic        req_v   [2];
    logic        we_v    [2];
    logic [31:0] addr_v  [2];
    logic [31:0] wdata_v [2];
    logic [31:0] cpu_rdata, ld_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        cpu_ready, ld_ready, mem_en, mem_we, mem_ack, owner, err;

    mem_arbiter #(.AW(32), .DW(32), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .reset     (rst_n),
        .cpu_req   (req_v[0]),
        .cpu_we    (we_v[0]),
        .cpu_addr  (addr_v[0]),
        .cpu_wdata (wdata_v[0]),
        .cpu_rdata (cpu_rdata),
        .cpu_ready (cpu_ready),
        .ld_req    (req_v[1]),
        .ld_we     (we_v[1]),
        .ld_addr   (addr_v[1]),
        .ld_wdata  (wdata_v[1]),
        .ld_rdata  (ld_rdata),
        .ld_ready  (ld_ready),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .owner     (owner),
        .err       (err)
    );

    // Reference model state: arbitration pointer, earliest next grant edge, golden memory.
    int          cyc;
    int          free_edge;
    int          last_model;
    int          wait_mode;
    int          raise_cyc [2];
    logic [31:0] exp_rdata [2];
    bit          spur_en;
    logic [31:0] golden [logic [31:0]];
    int          n_checks;
    int          n_fail;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (golden.exists(a)) return golden[a];
        return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
    endfunction

    function automatic logic rdy(input int r);
        return (r == 1) ? ld_ready : cpu_ready;
    endfunction

    function automatic logic [31:0] rd(input int r);
        return (r == 1) ? ld_rdata : cpu_rdata;
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Memory responder and protocol/arbitration model, evaluated on every falling edge.
    initial begin : responder
        bit          in_txn, done_pend, done_err, el0, el1;
        int          own, done_own, wl, acc_cycles, g, g_exp;
        logic        cur_we;
        logic [31:0] cur_addr, cur_wdata;
        in_txn = 0; done_pend = 0; done_err = 0; own = 0; done_own = 0;
        wl = 0; acc_cycles = 0; cur_we = 0; cur_addr = '0; cur_wdata = '0;
        mem_ack = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (!rst_n) begin
                in_txn = 0;
                done_pend = 0;
                continue;
            end
            if (in_txn && !mem_en) begin
`ifdef MEM_ARB_TIMEOUT_EN
                check("timeout_len", 64'(acc_cycles), 64'(TO));
                done_pend = 1;
                done_own = own;
                done_err = 1;
                exp_rdata[own] = 32'hDEADBEEF;
`else
                check("mem_en_held", 64'(mem_en), 64'd1);
`endif
                in_txn = 0;
            end
            check("cpu_ready", 64'(cpu_ready), 64'(done_pend && done_own == 0));
            check("ld_ready", 64'(ld_ready), 64'(done_pend && done_own == 1));
            if (done_pend) begin
                check("err", 64'(err), 64'(done_err));
                check("owner_done", 64'(owner), 64'(done_own));
                last_model = done_own;
                free_edge = cyc + 2;
                done_pend = 0;
            end
            if (mem_en) begin
                if (!in_txn) begin
                    g = cyc;
                    el0 = req_v[0] && raise_cyc[0] < g;
                    el1 = req_v[1] && raise_cyc[1] < g;
                    own = (el0 && el1) ? 1 - last_model : (el1 ? 1 : 0);
                    check("grant_eligible", 64'(el0 || el1), 64'd1);
                    check("owner", 64'(owner), 64'(own));
                    g_exp = (free_edge > raise_cyc[own] + 1) ? free_edge : raise_cyc[own] + 1;
                    check("grant_edge", 64'(g), 64'(g_exp));
                    cur_we = we_v[own];
                    cur_addr = addr_v[own];
                    cur_wdata = wdata_v[own];
                    wl = (wait_mode < 0) ? int'($urandom_range(0, 3)) : wait_mode;
                    acc_cycles = 0;
                    in_txn = 1;
                end
                acc_cycles++;
                check("mem_we", 64'(mem_we), 64'(cur_we));
                check("mem_addr", 64'(mem_addr), 64'(cur_addr));
                check("mem_wdata", 64'(mem_wdata), 64'(cur_wdata));
                if (wl == 0) begin
                    mem_ack = 1'b1;
                    if (cur_we) begin
                        mem_rdata = $urandom;
                        golden[cur_addr] = cur_wdata;
                    end else begin
                        mem_rdata = mem_rd(cur_addr);
                    end
                    exp_rdata[own] = mem_rdata;
                    done_pend = 1;
                    done_own = own;
                    done_err = 0;
                    in_txn = 0;
                end else begin
                    wl--;
                end
            end else if (spur_en) begin
                mem_ack = ($urandom_range(0, 1) == 1);
            end
        end
    end

    task automatic do_txn(input int r, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input bit hold);
        int n;
        @(posedge clk);
        #1;
        we_v[r] = we;
        addr_v[r] = addr;
        wdata_v[r] = wdata;
        req_v[r] = 1'b1;
        raise_cyc[r] = cyc;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rdy(r) && n < 400);
        if (!rdy(r)) begin
            if (r == 1) check("ld_ready_bound", 64'(ld_ready), 64'd1);
            else        check("cpu_ready_bound", 64'(cpu_ready), 64'd1);
            hold = 0;
        end else begin
            #1;
            if (r == 1) check("ld_rdata", 64'(rd(r)), 64'(exp_rdata[r]));
            else        check("cpu_rdata", 64'(rd(r)), 64'(exp_rdata[r]));
        end
        if (!hold) begin
            @(posedge clk);
            #1;
            req_v[r] = 1'b0;
        end
    endtask

    task automatic requester(input int r, input int n);
        bit hold;
        hold = 0;
        for (int i = 0; i < n; i++) begin
            if (!hold) repeat ($urandom_range(0, 3)) @(posedge clk);
            hold = (i < n - 1) && ($urandom_range(0, 3) == 0);
            do_txn(r, 1'($urandom_range(0, 1)), 32'h300 + 32'($urandom_range(0, 15)) * 32'd4,
                   $urandom, hold);
        end
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        free_edge = 0; last_model = 1; wait_mode = 0; spur_en = 0;
        for (int i = 0; i < 2; i++) begin
            req_v[i] = 1'b0; we_v[i] = 1'b0; addr_v[i] = '0; wdata_v[i] = '0;
            raise_cyc[i] = 0; exp_rdata[i] = '0;
        end
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mem_en", 64'(mem_en), 64'd0);
        check("rst_mem_we", 64'(mem_we), 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        check("rst_cpu_ready", 64'(cpu_ready), 64'd0);
        check("rst_ld_ready", 64'(ld_ready), 64'd0);
        check("rst_cpu_rdata", 64'(cpu_rdata), 64'd0);
        check("rst_ld_rdata", 64'(ld_rdata), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_owner", 64'(owner), 64'd1);
        rst_n = 1'b1;
        free_edge = cyc + 1;
        last_model = 1;

        // First access straight after reset: zero-wait read of 0x100.
        golden[32'h100] = 32'h12345678;
        do_txn(0, 1'b0, 32'h100, 32'h0, 1'b0);
        check("first_rdata", 64'(cpu_rdata), 64'h12345678);

        // Loader served last, then two simultaneous-request ties.
        do_txn(1, 1'b0, 32'h104, 32'h0, 1'b0);
        repeat (2) begin
            fork
                do_txn(0, 1'b0, 32'h100, 32'h0, 1'b0);
                do_txn(1, 1'b0, 32'h104, 32'h0, 1'b0);
            join
        end

        // Loader write with four wait states, then CPU reads it back.
        wait_mode = 4;
        do_txn(1, 1'b1, 32'h200, 32'hCAFEF00D, 1'b0);
        wait_mode = 0;
        do_txn(0, 1'b0, 32'h200, 32'h0, 1'b0);
        check("readback", 64'(cpu_rdata), 64'hCAFEF00D);

        // Stray acks while idle must be ignored.
        spur_en = 1;
        repeat (4) @(posedge clk);
        #1 spur_en = 0;

        // CPU streams back-to-back while the loader asks once.
        fork
            begin
                for (int i = 0; i < 4; i++)
                    do_txn(0, 1'b0, 32'h120 + 32'(i) * 32'd4, 32'h0, i < 3);
            end
            begin
                @(posedge clk);
                do_txn(1, 1'b1, 32'h140, 32'h0BADF00D, 1'b0);
            end
        join

        // Reset in the middle of ACCESS: no ready, re-grant afterwards.
        wait_mode = 6;
        fork
            do_txn(0, 1'b0, 32'h108, 32'h0, 1'b0);
            begin
                repeat (4) @(posedge clk);
                #2;
                check("pre_rst_mem_en", 64'(mem_en), 64'd1);
                rst_n = 1'b0;
                #1;
                check("rst_mid_mem_en", 64'(mem_en), 64'd0);
                check("rst_mid_cpu_ready", 64'(cpu_ready), 64'd0);
                check("rst_mid_owner", 64'(owner), 64'd1);
                wait_mode = 0;
                repeat (2) @(posedge clk);
                #1;
                rst_n = 1'b1;
                free_edge = cyc + 1;
                last_model = 1;
            end
        join

`ifdef MEM_ARB_TIMEOUT_EN
        wait_mode = 1000;
        do_txn(0, 1'b0, 32'h10C, 32'h0, 1'b0);
        check("timeout_rdata", 64'(cpu_rdata), 64'hDEADBEEF);
        wait_mode = 0;
        do_txn(0, 1'b0, 32'h100, 32'h0, 1'b0);
        check("after_timeout_rdata", 64'(cpu_rdata), 64'h12345678);
`endif

        // Random traffic from both requesters with random wait states and stray acks.
        wait_mode = -1;
        spur_en = 1;
        fork
            requester(0, 60);
            requester(1, 60);
        join
        spur_en = 0;
        repeat (5) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter for the single unified memory of the multicycle CPU. It shares the one memory port between the CPU (instruction fetch and data access, already muxed by `iord`) and a loader/debug requester that writes programs and inspects memory. Each transaction is latched at grant and driven to memory until the memory acknowledges. The read data and a one-cycle ready pulse are then returned to the owner. The block sits between `mips` and the memory model, replacing the direct `pc`/`aluout` to memory connection.

## Interface
Parameters:
- `AW`, 32, address width
- `DW`, 32, data width
- `TIMEOUT`, 64, maximum cycles `mem_en` may wait for `mem_ack` (only with the macro)

Ports:
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `cpu_req`  in  1  CPU access request, held until `cpu_ready`
- `cpu_we`  in  1  CPU write enable
- `cpu_addr`  in  AW  CPU byte address
- `cpu_wdata`  in  DW  CPU write data
- `cpu_rdata`  out  DW  CPU read data, valid while `cpu_ready`
- `cpu_ready`  out  1  one-cycle completion pulse to CPU
- `ld_req`, `ld_we`, `ld_addr`, `ld_wdata`, `ld_rdata`, `ld_ready`  same as the CPU set, for the loader
- `mem_en`  out  1  memory access strobe
- `mem_we`  out  1  memory write enable
- `mem_addr`  out  AW  memory address
- `mem_wdata`  out  DW  memory write data
- `mem_rdata`  in  DW  memory read data, valid with `mem_ack`
- `mem_ack`  in  1  memory completion, one cycle
- `owner`  out  1  current or last grant: 0 = CPU, 1 = loader
- `err`  out  1  timeout flag, valid with a ready pulse (tied 0 without the macro)

## Operation
- FSM states: `IDLE`, `ACCESS`, `DONE`.
- **IDLE**
  - A request is eligible if its `req` is high and its `ready` is low in that cycle.
  - One eligible request: grant it.
  - Two eligible requests: round-robin, granting the requester not served last.
  - On grant, latch `we`/`addr`/`wdata` into internal registers, set `owner`, and go to `ACCESS`.
- **ACCESS**
  - `mem_en` = 1 and `mem_we`/`mem_addr`/`mem_wdata` come from the latched registers, held stable.
  - On `mem_ack`, capture `mem_rdata` into the owner's rdata register and go to `DONE`.
- **DONE**
  - The owner's `ready` = 1 for exactly this cycle; the rdata register holds its value until the next completion for that requester.
  - Return to `IDLE`, with the last-served pointer set to the owner.
- Write transactions return the `mem_rdata` captured at ack; requesters ignore it.
- Requester inputs are don't-care outside the grant cycle, since the transaction is latched.
- Requests are never dropped: a waiting requester is granted at the next `IDLE` in which it is eligible.
- `mem_ack` outside `ACCESS` is ignored.

Reset (asynchronous, `reset` = 0):
- State `IDLE`.
- `mem_en`, `mem_we`, `cpu_ready`, `ld_ready`, `err` = 0.
- `mem_addr`, `mem_wdata`, `cpu_rdata`, `ld_rdata` = 0.
- `owner` = 1 and last-served = loader, so the CPU wins the first tie.
- Reset during `ACCESS` aborts the transaction. No ready pulse is issued, and the requester re-requests after reset.

## Timing
- Request sampled at edge k (`IDLE`) -> `mem_en` high in cycle k+1 -> with zero-wait memory, `mem_ack` in k+1 -> `ready` in cycle k+2.
- Minimum occupancy is 3 cycles per transaction (IDLE, ACCESS, DONE).
- A wait-state memory adds one cycle per cycle that `mem_ack` is low.
- A requester holding `req` through its `ready` cycle is treated as issuing a new request, and is eligible in the following `IDLE`.
- All outputs are registered; there is no combinational path from `req` or `mem_ack` to any output.

## Configuration
`MEM_ARB_TIMEOUT_EN`

**Defined:**
- A counter runs in `ACCESS`.
- If `TIMEOUT` cycles pass with no `mem_ack`, the FSM goes to `DONE` with `err` = 1 for that pulse and the owner's rdata = 32'hDEADBEEF.
- The counter clears on every entry to `ACCESS`.

**Undefined:**
- `ACCESS` waits indefinitely for `mem_ack`.
- `err` is tied 0.
- No counter logic is present.

## Structure
- Shared package `mem_arb_pkg`:
  - state enum {`IDLE`, `ACCESS`, `DONE`}
  - owner enum {`OWN_CPU`, `OWN_LD`}
  - constant `ARB_ERR_DATA` = 32'hDEADBEEF
- Types `u1`/`u32` come from `common.svh`.
- One sub-module, `mem_arb_timer`: a loadable down-counter with an expiry pulse. It is instantiated only under `MEM_ARB_TIMEOUT_EN`.

## Test plan
- **Reset:** hold `reset` = 0 -> all outputs 0 and `owner` = 1. Release, then `cpu_req` read of 0x100 with `mem_rdata` = 0x1234_5678 and immediate ack -> `cpu_ready` at k+2 with `cpu_rdata` = 0x1234_5678.
- **Tie-break:** `cpu_req` and `ld_req` both rise at the same edge -> CPU served first, then loader. Repeat the tie -> CPU first again, since last-served is now the loader.
- **Wait states:** loader write of 0xCAFEF00D to 0x200 with `mem_ack` delayed 4 cycles -> `mem_addr`/`mem_wdata`/`mem_we` stable for all 5 `ACCESS` cycles, `ld_ready` one cycle after ack, `cpu_ready` stays 0.
- **Back-to-back and starvation:** CPU holds `req` continuously while the loader requests -> grants alternate CPU, LD, CPU; the loader waits no more than one transaction.
- **Reset mid-access:** assert reset during `ACCESS` -> `mem_en` drops immediately, no ready pulse. After release, the pending `cpu_req` is re-granted.
- **Timeout (`MEM_ARB_TIMEOUT_EN`, `TIMEOUT` = 8):** no ack -> `cpu_ready` with `err` = 1 and `cpu_rdata` = 32'hDEADBEEF, 8 cycles after `mem_en` rose. A next request with a normal ack -> `err` = 0.
